// File: rtl/fetch_sequencer_if.sv
// Bundle of signals between the fetch sequencer, its requester/decoder side
// and the instruction ROM.
//   slave  : the fetch sequencer (consumes control + ROM data, drives fetch outputs)
//   master : the environment (drives control + ROM data, observes fetch outputs)
// Signals:
//   start_i, stall_i, branch_valid_i, branch_rel_i, branch_target_i : control in
//   rom_addr_o / rom_data_i : combinational ROM port
//   inst_o, inst_valid_o, pc_o : registered instruction to decode
//   halted_o, run_cycles_o : status
interface fetch_sequencer_if #(
  parameter int unsigned PC_W   = 7,
  parameter int unsigned INST_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              start_i;
  logic              stall_i;
  logic              branch_valid_i;
  logic              branch_rel_i;
  logic [PC_W-1:0]   branch_target_i;
  logic [PC_W-1:0]   rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic [INST_W-1:0] inst_o;
  logic              inst_valid_o;
  logic [PC_W-1:0]   pc_o;
  logic              halted_o;
  logic [CNT_W-1:0]  run_cycles_o;

  modport slave (
    input  start_i, stall_i, branch_valid_i, branch_rel_i, branch_target_i,
           rom_data_i,
    output rom_addr_o, inst_o, inst_valid_o, pc_o, halted_o, run_cycles_o
  );

  modport master (
    output start_i, stall_i, branch_valid_i, branch_rel_i, branch_target_i,
           rom_data_i,
    input  rom_addr_o, inst_o, inst_valid_o, pc_o, halted_o, run_cycles_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 128-entry instruction ROM.
// Owns the fetch PC (driven straight out as the ROM address), captures the
// same-cycle ROM data into inst_o for decode, and handles stall, absolute /
// relative branch redirect, program start/restart and halt detection.
// Ports:
//   clk_i   : system clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : fetch_sequencer_if.slave (control in, ROM port, decode outputs)
module fetch_sequencer #(
  parameter int unsigned             PC_W        = 7,
  parameter int unsigned             INST_W      = 8,
  parameter logic [INST_W-1:0]       HALT_OPCODE = 8'hFF,
  parameter int unsigned             CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic              inst_valid_q;
  logic              halted_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [PC_W-1:0]   br_target;
  logic [CNT_W-1:0]  cnt_inc;

  // Relative targets are taken from the instruction being redirected (pc_o),
  // not from the fetch PC which is already one ahead.
  always_comb begin
    br_target = bus.branch_target_i;
    if (bus.branch_rel_i) br_target = pc_q + bus.branch_target_i;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      fetch_pc     <= '0;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          inst_valid_q <= 1'b0;
          if (bus.start_i) begin
            state    <= S_RUN;
            fetch_pc <= '0;
            cnt_q    <= '0;
          end
        end

        S_RUN: begin
          if (!bus.stall_i) begin
            if (bus.start_i) begin
              fetch_pc     <= '0;
              inst_valid_q <= 1'b0;
              cnt_q        <= '0;
            end else if (bus.branch_valid_i) begin
              // Redirect; the word fetched this cycle is dropped as a bubble.
              fetch_pc     <= br_target;
              inst_valid_q <= 1'b0;
              cnt_q        <= cnt_inc;
            end else begin
              inst_q       <= bus.rom_data_i;
              pc_q         <= fetch_pc;
              inst_valid_q <= 1'b1;
              cnt_q        <= cnt_inc;
              if (bus.rom_data_i == HALT_OPCODE) begin
                // Halt word is still presented once; fetch PC parks on it.
                state    <= S_HALT;
                halted_q <= 1'b1;
              end else begin
                fetch_pc <= fetch_pc + PC_ONE;
              end
            end
          end
        end

        S_HALT: begin
          inst_valid_q <= 1'b0;
          if (bus.start_i) begin
            state    <= S_RUN;
            fetch_pc <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr_o   = fetch_pc;
  assign bus.inst_o       = inst_q;
  assign bus.inst_valid_o = inst_valid_q;
  assign bus.pc_o         = pc_q;
  assign bus.halted_o     = halted_q;
  assign bus.run_cycles_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int unsigned PC_W   = 7;
  localparam int unsigned INST_W = 8;
  localparam int unsigned CNT_W  = 6;   // narrow counter so saturation is reachable

  logic clk;
  logic rst;

  fetch_sequencer_if #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(
    .PC_W(PC_W), .INST_W(INST_W), .HALT_OPCODE(8'hFF), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [INST_W-1:0] rom [128];
  always_comb bus.rom_data_i = rom[bus.rom_addr_o];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sl, input logic bv,
                       input logic br, input logic [PC_W-1:0] tg);
    bus.start_i         = st;
    bus.stall_i         = sl;
    bus.branch_valid_i  = bv;
    bus.branch_rel_i    = br;
    bus.branch_target_i = tg;
  endtask

  typedef struct {
    logic              start, stall, bv, brel;
    logic [PC_W-1:0]   tgt;
    logic              dchk;   // compare inst_o/pc_o on this row
    logic              valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   addr;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic st, input logic sl, input logic bv,
                              input logic br, input logic [PC_W-1:0] tg,
                              input logic dc, input logic v, input logic [INST_W-1:0] in,
                              input logic [PC_W-1:0] p, input logic [PC_W-1:0] a,
                              input logic [CNT_W-1:0] c);
    vec_t r;
    r.start = st; r.stall = sl; r.bv = bv; r.brel = br; r.tgt = tg;
    r.dchk = dc; r.valid = v; r.inst = in; r.pc = p; r.addr = a; r.cnt = c;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = INST_W'(i);
    drive(0, 0, 0, 0, '0);
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.inst_valid_o), 0);
    chk("rst_inst", 32'(bus.inst_o), 0);
    chk("rst_pc", 32'(bus.pc_o), 0);
    chk("rst_addr", 32'(bus.rom_addr_o), 0);
    chk("rst_halted", 32'(bus.halted_o), 0);
    chk("rst_cnt", 32'(bus.run_cycles_o), 0);
    rst = 1'b0;
    step();
    chk("idle_valid", 32'(bus.inst_valid_o), 0);

    //            st sl bv br tgt    dc v inst   pc     addr   cnt
    vecs[0]  = mk(1, 0, 0, 0, 7'h00, 1, 0, 8'h00, 7'h00, 7'h00, 0);
    vecs[1]  = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h00, 7'h00, 7'h01, 1);
    vecs[2]  = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h01, 7'h01, 7'h02, 2);
    vecs[3]  = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h02, 7'h02, 7'h03, 3);
    vecs[4]  = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h03, 7'h03, 7'h04, 4);
    vecs[5]  = mk(0, 0, 1, 0, 7'h40, 0, 0, 8'h00, 7'h00, 7'h40, 5);
    vecs[6]  = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h40, 7'h40, 7'h41, 6);
    vecs[7]  = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h41, 7'h41, 7'h42, 7);
    vecs[8]  = mk(0, 1, 1, 0, 7'h10, 1, 1, 8'h41, 7'h41, 7'h42, 7);
    vecs[9]  = mk(0, 1, 1, 0, 7'h10, 1, 1, 8'h41, 7'h41, 7'h42, 7);
    vecs[10] = mk(0, 0, 1, 0, 7'h10, 0, 0, 8'h00, 7'h00, 7'h10, 8);
    vecs[11] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h10, 7'h10, 7'h11, 9);
    vecs[12] = mk(0, 0, 1, 1, 7'h7E, 0, 0, 8'h00, 7'h00, 7'h0E, 10);
    vecs[13] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h0E, 7'h0E, 7'h0F, 11);
    vecs[14] = mk(1, 0, 1, 0, 7'h50, 0, 0, 8'h00, 7'h00, 7'h00, 0);
    vecs[15] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h00, 7'h00, 7'h01, 1);
    vecs[16] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h01, 7'h01, 7'h02, 2);
    vecs[17] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h02, 7'h02, 7'h03, 3);
    vecs[18] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h03, 7'h03, 7'h04, 4);
    vecs[19] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h04, 7'h04, 7'h05, 5);
    vecs[20] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h05, 7'h05, 7'h06, 6);
    vecs[21] = mk(0, 1, 0, 0, 7'h00, 1, 1, 8'h05, 7'h05, 7'h06, 6);
    vecs[22] = mk(0, 1, 0, 0, 7'h00, 1, 1, 8'h05, 7'h05, 7'h06, 6);
    vecs[23] = mk(0, 1, 0, 0, 7'h00, 1, 1, 8'h05, 7'h05, 7'h06, 6);
    vecs[24] = mk(0, 0, 0, 0, 7'h00, 1, 1, 8'h06, 7'h06, 7'h07, 7);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].bv, vecs[i].brel, vecs[i].tgt);
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.inst_valid_o), 32'(vecs[i].valid));
      chk($sformatf("v%0d_addr", i), 32'(bus.rom_addr_o), 32'(vecs[i].addr));
      chk($sformatf("v%0d_cnt", i), 32'(bus.run_cycles_o), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_halted", i), 32'(bus.halted_o), 0);
      if (vecs[i].dchk) begin
        chk($sformatf("v%0d_inst", i), 32'(bus.inst_o), 32'(vecs[i].inst));
        chk($sformatf("v%0d_pc", i), 32'(bus.pc_o), 32'(vecs[i].pc));
      end
    end

    // PC wrap 126,127,0,1 and relative +5 from 125 wrapping to 2
    drive(1, 0, 0, 0, '0); step();
    drive(0, 0, 0, 0, '0); step();
    chk("wrap_pc0", 32'(bus.pc_o), 0);
    drive(0, 0, 1, 0, 7'd126); step();
    chk("wrap_bubble", 32'(bus.inst_valid_o), 0);
    drive(0, 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wrap_pc_%0d", k), 32'(bus.pc_o), 32'((126 + k) % 128));
      chk($sformatf("wrap_valid_%0d", k), 32'(bus.inst_valid_o), 1);
    end
    drive(0, 0, 1, 0, 7'd125); step();
    drive(0, 0, 0, 0, '0); step();
    chk("rel_from_pc", 32'(bus.pc_o), 125);
    drive(0, 0, 1, 1, 7'd5); step();
    chk("rel_bubble", 32'(bus.inst_valid_o), 0);
    chk("rel_addr", 32'(bus.rom_addr_o), 2);
    drive(0, 0, 0, 0, '0); step();
    chk("rel_pc", 32'(bus.pc_o), 2);
    chk("rel_inst", 32'(bus.inst_o), 2);

    // Counter saturation at 2^CNT_W-1 = 63
    drive(1, 0, 0, 0, '0); step();
    chk("sat_clear", 32'(bus.run_cycles_o), 0);
    drive(0, 0, 0, 0, '0);
    for (int k = 0; k < 62; k++) step();
    chk("sat_62", 32'(bus.run_cycles_o), 62);
    step();
    chk("sat_63", 32'(bus.run_cycles_o), 63);
    for (int k = 0; k < 7; k++) step();
    chk("sat_hold", 32'(bus.run_cycles_o), 63);

    // Halt at address 4
    rom[4] = 8'hFF;
    drive(1, 0, 0, 0, '0); step();
    chk("h_start_valid", 32'(bus.inst_valid_o), 0);
    drive(0, 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("h_pre_inst_%0d", k), 32'(bus.inst_o), 32'(k));
    end
    step();
    chk("h_inst", 32'(bus.inst_o), 32'hFF);
    chk("h_pc", 32'(bus.pc_o), 4);
    chk("h_valid", 32'(bus.inst_valid_o), 1);
    chk("h_cnt", 32'(bus.run_cycles_o), 5);
    step();
    chk("h_halted", 32'(bus.halted_o), 1);
    chk("h_valid_after", 32'(bus.inst_valid_o), 0);
    drive(0, 0, 1, 0, 7'h20); step();
    chk("h_br_ignored_addr", 32'(bus.rom_addr_o), 4);
    chk("h_br_ignored_valid", 32'(bus.inst_valid_o), 0);
    chk("h_cnt_hold", 32'(bus.run_cycles_o), 5);
    chk("h_still_halted", 32'(bus.halted_o), 1);
    drive(1, 0, 0, 0, '0); step();
    chk("h_restart_halted", 32'(bus.halted_o), 0);
    chk("h_restart_cnt", 32'(bus.run_cycles_o), 0);
    chk("h_restart_addr", 32'(bus.rom_addr_o), 0);
    drive(0, 0, 0, 0, '0); step();
    chk("h_restart_inst", 32'(bus.inst_o), 0);
    chk("h_restart_v", 32'(bus.inst_valid_o), 1);
    rom[4] = 8'h04;

    // Reset mid-RUN
    step(); step();
    chk("mr_pre_inst", 32'(bus.inst_o), 2);
    rst = 1'b1; step();
    chk("mr_valid", 32'(bus.inst_valid_o), 0);
    chk("mr_inst", 32'(bus.inst_o), 0);
    chk("mr_pc", 32'(bus.pc_o), 0);
    chk("mr_addr", 32'(bus.rom_addr_o), 0);
    chk("mr_cnt", 32'(bus.run_cycles_o), 0);
    chk("mr_halted", 32'(bus.halted_o), 0);
    rst = 1'b0; step(); step();
    chk("mr_idle_valid", 32'(bus.inst_valid_o), 0);
    chk("mr_idle_addr", 32'(bus.rom_addr_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
